// File: rtl/alu_issue.sv
// Operand-issue stage for the 16-bit ALU. It resolves EX/WB forwarding, selects the B operand,
// and feeds registered op/a/b through a two-entry skid buffer (output register plus skid register).
module alu_issue #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              ex_fwd_en,
    input  logic [REG_AW-1:0] ex_fwd_rd,
    input  logic [DATA_W-1:0] ex_fwd_val,
    input  logic              wb_fwd_en,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [DATA_W-1:0] wb_fwd_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [REG_AW-1:0] out_rd
);

    // Source indices are kept with each entry so that a stalled entry can be re-forwarded.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              use_imm;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    entry_t out_ent, skid_ent;
    entry_t new_ent, out_fwd, skid_fwd;
    logic   skid_valid;
    logic   accept, advance;

    // A nonzero index excludes rd==0, so forwards to r0 are never taken.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [REG_AW-1:0] idx,
        input logic [DATA_W-1:0] val,
        input logic              ex_en,
        input logic [REG_AW-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_val,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_val
    );
        if (idx == '0)                   return '0;
        else if (ex_en && ex_rd == idx)  return ex_val;
        else if (wb_en && wb_rd == idx)  return wb_val;
        else                             return val;
    endfunction

    function automatic entry_t refresh(
        input entry_t            e,
        input logic              ex_en,
        input logic [REG_AW-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_val,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_val
    );
        entry_t r;
        r   = e;
        r.a = resolve(e.rs, e.a, ex_en, ex_rd, ex_val, wb_en, wb_rd, wb_val);
        if (!e.use_imm)
            r.b = resolve(e.rt, e.b, ex_en, ex_rd, ex_val, wb_en, wb_rd, wb_val);
        return r;
    endfunction

    always_comb begin
        new_ent         = '0;
        new_ent.op      = in_op;
        new_ent.rs      = in_rs;
        new_ent.rt      = in_rt;
        new_ent.rd      = in_rd;
        new_ent.use_imm = in_use_imm;
        new_ent.a       = resolve(in_rs, in_rs_val, ex_fwd_en, ex_fwd_rd, ex_fwd_val,
                                  wb_fwd_en, wb_fwd_rd, wb_fwd_val);
        new_ent.b       = in_use_imm ? in_imm
                        : resolve(in_rt, in_rt_val, ex_fwd_en, ex_fwd_rd, ex_fwd_val,
                                  wb_fwd_en, wb_fwd_rd, wb_fwd_val);
        out_fwd  = refresh(out_ent, ex_fwd_en, ex_fwd_rd, ex_fwd_val,
                           wb_fwd_en, wb_fwd_rd, wb_fwd_val);
        skid_fwd = refresh(skid_ent, ex_fwd_en, ex_fwd_rd, ex_fwd_val,
                           wb_fwd_en, wb_fwd_rd, wb_fwd_val);
    end

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign advance  = !out_valid || out_ready;

    // An accept is only possible with the skid empty, so the skid never holds more than one entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ent    <= '0;
            skid_ent   <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (advance) begin
            if (skid_valid) begin
                out_ent    <= skid_fwd;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_ent   <= new_ent;
                out_valid <= 1'b1;
            end else begin
                out_ent   <= out_fwd;
                out_valid <= 1'b0;
            end
        end else begin
            out_ent <= out_fwd;
            if (accept) begin
                skid_ent   <= new_ent;
                skid_valid <= 1'b1;
            end else begin
                skid_ent <= skid_fwd;
            end
        end
    end

    assign op     = out_ent.op;
    assign a      = out_ent.a;
    assign b      = out_ent.b;
    assign out_rd = out_ent.rd;

endmodule

// File: tb/tb_alu_issue.sv
// Directed and random checks of alu_issue against a queue-based reference model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_use_imm;
    logic [2:0]  in_op, in_rs, in_rt, in_rd;
    logic [15:0] in_rs_val, in_rt_val, in_imm;
    logic        ex_fwd_en, wb_fwd_en;
    logic [2:0]  ex_fwd_rd, wb_fwd_rd;
    logic [15:0] ex_fwd_val, wb_fwd_val;
    logic        out_valid, out_ready;
    logic [2:0]  op, out_rd;
    logic [15:0] a, b;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
        .ex_fwd_en(ex_fwd_en), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_val(ex_fwd_val),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_val(wb_fwd_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .a(a), .b(b), .out_rd(out_rd)
    );

    typedef struct {
        logic [2:0]  op, rs, rt, rd;
        logic        use_imm;
        logic [15:0] a, b;
    } ment_t;

    ment_t q[$];   // model: instructions held by the stage, oldest first (at most two)
    int checks   = 0;
    int failures = 0;

    function automatic logic [15:0] fwd(input logic [2:0] idx, input logic [15:0] v);
        if (idx == 3'd0) return 16'h0;
        if (ex_fwd_en && ex_fwd_rd == idx) return ex_fwd_val;
        if (wb_fwd_en && wb_fwd_rd == idx) return wb_fwd_val;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, {15'd0, out_valid}, {15'd0, q.size() > 0});
        chk({tag, "_ready"}, {15'd0, in_ready}, {15'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk({tag, "_op"}, {13'd0, op}, {13'd0, q[0].op});
            chk({tag, "_a"}, a, q[0].a);
            chk({tag, "_b"}, b, q[0].b);
            chk({tag, "_rd"}, {13'd0, out_rd}, {13'd0, q[0].rd});
        end
    endtask

    // Applies this cycle's inputs to the model, then crosses the rising edge.
    task automatic tick();
        bit    cons, acc;
        ment_t e;
        cons = (q.size() > 0) && out_ready;
        acc  = in_valid && (q.size() < 2);
        if (flush) q.delete();
        else begin
            foreach (q[i]) begin
                q[i].a = fwd(q[i].rs, q[i].a);
                if (!q[i].use_imm) q[i].b = fwd(q[i].rt, q[i].b);
            end
            if (cons) void'(q.pop_front());
            if (acc) begin
                e.op = in_op; e.rs = in_rs; e.rt = in_rt; e.rd = in_rd;
                e.use_imm = in_use_imm;
                e.a = fwd(in_rs, in_rs_val);
                e.b = in_use_imm ? in_imm : fwd(in_rt, in_rt_val);
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_rs_val = 0; in_rt_val = 0; in_imm = 0; in_use_imm = 0;
        ex_fwd_en = 0; ex_fwd_rd = 0; ex_fwd_val = 0;
        wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_val = 0;
        out_ready = 1;
    endtask

    task automatic push(input logic [2:0] o, input logic [2:0] rs, input logic [15:0] rsv,
                        input logic [2:0] rt, input logic [15:0] rtv, input logic [2:0] rd);
        in_valid = 1; in_op = o; in_rs = rs; in_rs_val = rsv; in_rt = rt; in_rt_val = rtv;
        in_rd = rd; in_use_imm = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(negedge clk);
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_op", {13'd0, op}, 16'd0);
        chk("rst_a", a, 16'd0);
        chk("rst_b", b, 16'd0);
        chk("rst_rd", {13'd0, out_rd}, 16'd0);
        rst_n = 1;
        @(negedge clk);

        // basic issue, one cycle latency
        push(3'd0, 3'd1, 16'd23485, 3'd2, 16'd10234, 3'd5);
        tick(); in_valid = 0;
        chk("t1_valid", {15'd0, out_valid}, 16'd1);
        chk("t1_a", a, 16'd23485);
        chk("t1_b", b, 16'd10234);
        chk("t1_sum", a + b, 16'h83B7);
        check_model("t1");
        tick();

        // EX beats WB
        push(3'd1, 3'd3, 16'd5, 3'd0, 16'd0, 3'd1);
        ex_fwd_en = 1; ex_fwd_rd = 3; ex_fwd_val = 16'h1234;
        wb_fwd_en = 1; wb_fwd_rd = 3; wb_fwd_val = 16'h5678;
        tick(); idle();
        chk("t2_a", a, 16'h1234);
        check_model("t2");
        tick();

        // r0 reads zero, forward to r0 ignored
        push(3'd2, 3'd0, 16'hFFFF, 3'd0, 16'h0, 3'd2);
        ex_fwd_en = 1; ex_fwd_rd = 0; ex_fwd_val = 16'd7;
        tick(); idle();
        chk("t3_a", a, 16'h0000);
        check_model("t3");
        tick();

        // back-pressure: two held, third refused, then in-order drain
        out_ready = 0;
        push(3'd1, 3'd1, 16'd101, 3'd0, 16'd0, 3'd1); tick(); check_model("t4_1");
        push(3'd2, 3'd1, 16'd102, 3'd0, 16'd0, 3'd2); tick();
        chk("t4_ready_lo", {15'd0, in_ready}, 16'd0);
        push(3'd3, 3'd1, 16'd103, 3'd0, 16'd0, 3'd3); tick();
        chk("t4_still_first", a, 16'd101);
        check_model("t4_3");
        out_ready = 1;
        tick(); chk("t4_second", a, 16'd102); check_model("t4_d2");
        tick(); chk("t4_third", a, 16'd103); check_model("t4_d3");
        in_valid = 0;
        tick(); check_model("t4_empty");

        // WB result arriving during stall reaches the held rt operand
        out_ready = 0;
        push(3'd4, 3'd1, 16'd1, 3'd4, 16'd9, 3'd6); tick(); in_valid = 0;
        wb_fwd_en = 1; wb_fwd_rd = 4; wb_fwd_val = 16'h00AA; tick();
        wb_fwd_en = 0; tick();
        chk("t5_b_fwd", b, 16'h00AA);
        check_model("t5a");
        out_ready = 1; tick();
        // immediate is never forwarded
        out_ready = 0;
        push(3'd4, 3'd1, 16'd1, 3'd4, 16'd9, 3'd6); in_use_imm = 1; in_imm = 16'hFFF0;
        tick(); in_valid = 0;
        wb_fwd_en = 1; wb_fwd_rd = 4; wb_fwd_val = 16'h00AA; tick();
        chk("t5_b_imm", b, 16'hFFF0);
        check_model("t5b");
        idle(); tick();

        // flush drops held entries and the same-cycle input
        out_ready = 0;
        push(3'd1, 3'd2, 16'd11, 3'd0, 16'd0, 3'd1); tick();
        push(3'd2, 3'd2, 16'd12, 3'd0, 16'd0, 3'd2); tick();
        push(3'd3, 3'd2, 16'd13, 3'd0, 16'd0, 3'd3); flush = 1; tick();
        flush = 0; in_valid = 0;
        chk("t6_flush_valid", {15'd0, out_valid}, 16'd0);
        chk("t6_flush_ready", {15'd0, in_ready}, 16'd1);
        tick(); check_model("t6_after");

        // async reset mid-stream
        push(3'd5, 3'd3, 16'd44, 3'd0, 16'd0, 3'd4); tick(); in_valid = 0;
        chk("t6_pre_rst", {15'd0, out_valid}, 16'd1);
        #2 rst_n = 0;
        #1 chk("t6_async_rst", {15'd0, out_valid}, 16'd0);
        q.delete();
        @(negedge clk); rst_n = 1; idle();
        @(negedge clk);

        // random traffic with forwarding, back-pressure and occasional flush
        for (int i = 0; i < 600; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 39) == 0);
            in_op      = 3'($urandom); in_rs = 3'($urandom); in_rt = 3'($urandom);
            in_rd      = 3'($urandom); in_use_imm = 1'($urandom);
            in_rs_val  = 16'($urandom); in_rt_val = 16'($urandom); in_imm = 16'($urandom);
            ex_fwd_en  = 1'($urandom); ex_fwd_rd = 3'($urandom); ex_fwd_val = 16'($urandom);
            wb_fwd_en  = 1'($urandom); wb_fwd_rd = 3'($urandom); wb_fwd_val = 16'($urandom);
            tick();
            check_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
